// File: rtl/packet_assembler.sv
// Egress packet rebuilder: serialises headers A, B, C and a byte-aligned payload
// into one contiguous 64-bit stream, re-packing payload bytes 2 lanes up behind the 18 header bytes.
module packet_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        header_a_valid,
  input  logic        header_b_valid,
  input  logic        header_c_valid,
  input  logic [47:0] header_a,
  input  logic [47:0] header_b,
  input  logic [47:0] header_c,
  input  logic        payload_valid,
  input  logic [63:0] payload,
  input  logic [7:0]  byte_enable,
  input  logic        sop,
  input  logic        eop,
  output logic        payload_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [7:0]  out_byte_enable,
  output logic        out_sop,
  output logic        out_eop,
  output logic        proto_err
);

  typedef enum logic [1:0] {IDLE, HDR1, BODY, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [47:0] hdr_a_q, hdr_a_d, hdr_b_q, hdr_b_d, hdr_c_q, hdr_c_d;
  logic [2:0]  cap_q, cap_d;
  logic [15:0] carry_q, carry_d;
  logic        flush2_q, flush2_d;
  logic        first_q, first_d;
  logic        ov_q, ov_d;
  logic [63:0] od_q, od_d;
  logic [7:0]  obe_q, obe_d;
  logic        osop_q, osop_d;
  logic        oeop_q, oeop_d;
  logic        perr_q, perr_d;

  logic        slot_free, all_hdr, accept, any_hdr_v;
  logic [47:0] hdr_a_eff, hdr_b_eff;

  // Same-cycle header valids bypass the capture registers so beat0 can load at once.
  assign slot_free = !ov_q || out_ready;
  assign hdr_a_eff = header_a_valid ? header_a : hdr_a_q;
  assign hdr_b_eff = header_b_valid ? header_b : hdr_b_q;
  assign all_hdr   = (cap_q[0] || header_a_valid) && (cap_q[1] || header_b_valid) &&
                     (cap_q[2] || header_c_valid);
  assign any_hdr_v = header_a_valid || header_b_valid || header_c_valid;
  assign accept    = (state_q == BODY) && payload_valid && slot_free;

  assign payload_ready   = (state_q == BODY) && slot_free;
  assign out_valid       = ov_q;
  assign out_data        = od_q;
  assign out_byte_enable = obe_q;
  assign out_sop         = osop_q;
  assign out_eop         = oeop_q;
  assign proto_err       = perr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hdr_a_q  <= '0;
      hdr_b_q  <= '0;
      hdr_c_q  <= '0;
      cap_q    <= '0;
      carry_q  <= '0;
      flush2_q <= 1'b0;
      first_q  <= 1'b0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      obe_q    <= '0;
      osop_q   <= 1'b0;
      oeop_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hdr_a_q  <= hdr_a_d;
      hdr_b_q  <= hdr_b_d;
      hdr_c_q  <= hdr_c_d;
      cap_q    <= cap_d;
      carry_q  <= carry_d;
      flush2_q <= flush2_d;
      first_q  <= first_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
      obe_q    <= obe_d;
      osop_q   <= osop_d;
      oeop_q   <= oeop_d;
      perr_q   <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (all_hdr && slot_free) state_d = HDR1;
      HDR1:    if (slot_free) state_d = BODY;
      BODY:    if (accept && eop) state_d = byte_enable[6] ? FLUSH : IDLE;
      FLUSH:   if (slot_free) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hdr_a_d  = hdr_a_q;
    hdr_b_d  = hdr_b_q;
    hdr_c_d  = hdr_c_q;
    cap_d    = cap_q;
    carry_d  = carry_q;
    flush2_d = flush2_q;
    first_d  = first_q;
    ov_d     = slot_free ? 1'b0 : ov_q;
    od_d     = od_q;
    obe_d    = obe_q;
    osop_d   = osop_q;
    oeop_d   = oeop_q;
    perr_d   = perr_q;

    if (state_q != IDLE && any_hdr_v) perr_d = 1'b1;
    if ((state_q == IDLE || state_q == HDR1) && payload_valid) perr_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (header_a_valid) begin hdr_a_d = header_a; cap_d[0] = 1'b1; end
        if (header_b_valid) begin hdr_b_d = header_b; cap_d[1] = 1'b1; end
        if (header_c_valid) begin hdr_c_d = header_c; cap_d[2] = 1'b1; end
        if (all_hdr && slot_free) begin
          ov_d   = 1'b1;
          od_d   = {hdr_b_eff[15:0], hdr_a_eff};
          obe_d  = 8'hFF;
          osop_d = 1'b1;
          oeop_d = 1'b0;
        end
      end
      HDR1: begin
        if (slot_free) begin
          ov_d    = 1'b1;
          od_d    = {hdr_c_q[31:0], hdr_b_q[47:16]};
          obe_d   = 8'hFF;
          osop_d  = 1'b0;
          oeop_d  = 1'b0;
          carry_d = hdr_c_q[47:32];
          first_d = 1'b1;
        end
      end
      BODY: begin
        if (accept) begin
          ov_d    = 1'b1;
          od_d    = {payload[47:0], carry_q};
          osop_d  = 1'b0;
          carry_d = payload[63:48];
          first_d = 1'b0;
          if (first_q != sop) perr_d = 1'b1;
          // 7 or 8 valid bytes overflow this beat by 1 or 2 carry bytes.
          if (eop && byte_enable[6]) begin
            obe_d    = 8'hFF;
            oeop_d   = 1'b0;
            flush2_d = byte_enable[7];
          end else if (eop) begin
            obe_d  = {byte_enable[5:0], 2'b11};
            oeop_d = 1'b1;
            cap_d  = '0;
          end else begin
            obe_d  = 8'hFF;
            oeop_d = 1'b0;
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          ov_d   = 1'b1;
          od_d   = {48'h0, carry_q};
          obe_d  = flush2_q ? 8'h03 : 8'h01;
          osop_d = 1'b0;
          oeop_d = 1'b1;
          cap_d  = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_packet_assembler.sv
// Directed bench for packet_assembler: packet byte m carries value m+1 (headers 0x01..0x12,
// payload from 0x13), so every output beat is predictable from its position in the stream.
module tb_packet_assembler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        header_a_valid = 0, header_b_valid = 0, header_c_valid = 0;
  logic [47:0] header_a = '0, header_b = '0, header_c = '0;
  logic        payload_valid = 0;
  logic [63:0] payload = '0;
  logic [7:0]  byte_enable = '0;
  logic        sop = 0, eop = 0;
  logic        payload_ready, out_valid, out_sop, out_eop, proto_err;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [7:0]  out_byte_enable;

  localparam logic [47:0] HA = 48'h060504030201;
  localparam logic [47:0] HB = 48'h0C0B0A090807;
  localparam logic [47:0] HC = 48'h1211100F0E0D;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  be;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t q[$];
  int    n_cmp = 0, n_err = 0;
  int    stall_viol = 0, prdy_viol = 0, stall_seen = 0;
  logic  tog = 1'b0;
  logic        prev_stall = 1'b0;
  logic [74:0] prev_vec = '0;

  packet_assembler dut (
    .clk(clk), .rst(rst),
    .header_a_valid(header_a_valid), .header_b_valid(header_b_valid),
    .header_c_valid(header_c_valid),
    .header_a(header_a), .header_b(header_b), .header_c(header_c),
    .payload_valid(payload_valid), .payload(payload), .byte_enable(byte_enable),
    .sop(sop), .eop(eop), .payload_ready(payload_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_byte_enable(out_byte_enable), .out_sop(out_sop), .out_eop(out_eop),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Collect accepted beats and note any output change while stalled.
  always @(negedge clk) begin
    if (!rst && prev_stall && {out_valid, out_data, out_byte_enable, out_sop, out_eop} !== prev_vec)
      stall_viol++;
    if (!rst && out_valid && !out_ready && payload_ready) prdy_viol++;
    if (!rst && out_valid && !out_ready) stall_seen++;
    prev_stall = !rst && out_valid && !out_ready;
    prev_vec   = {out_valid, out_data, out_byte_enable, out_sop, out_eop};
    if (!rst && out_valid && out_ready) begin
      beat_t b;
      b.d = out_data; b.be = out_byte_enable; b.sop = out_sop; b.eop = out_eop;
      q.push_back(b);
    end
  end

  function automatic logic [63:0] pbeat(int k);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(8'h13 + 8*k + i);
    return r;
  endfunction

  function automatic logic [63:0] exp_data(int j);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(8*j + i + 1);
    return r;
  endfunction

  function automatic logic [7:0] exp_be(int j, int total);
    int rem;
    rem = total - 8*j;
    if (rem >= 8) return 8'hFF;
    return 8'((1 << rem) - 1);
  endfunction

  function automatic logic [63:0] be_mask(logic [7:0] be);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (tog) out_ready = ~out_ready;
  endtask

  task automatic send_headers();
    header_a = HA; header_b = HB; header_c = HC;
    header_a_valid = 1; header_b_valid = 1; header_c_valid = 1;
    tick();
    header_a_valid = 0; header_b_valid = 0; header_c_valid = 0;
  endtask

  // Beat1 in the output register means the DUT has entered BODY.
  task automatic wait_body(output bit ok);
    for (int i = 0; i < 50 && !(out_valid && !out_sop && !out_eop); i++) tick();
    ok = out_valid && !out_sop && !out_eop;
  endtask

  task automatic send_beats(input int k0, input int k1, input int nb,
                            input logic [7:0] last_be, output bit ok);
    bit acc;
    ok = 1;
    for (int k = k0; k < k1; k++) begin
      payload_valid = 1; payload = pbeat(k);
      byte_enable = (k == nb-1) ? last_be : 8'hFF;
      sop = (k == 0); eop = (k == nb-1);
      acc = 0;
      for (int i = 0; i < 50 && !acc; i++) begin
        #1;
        acc = payload_ready;
        tick();
      end
      if (!acc) ok = 0;
    end
    payload_valid = 0; sop = 0; eop = 0;
  endtask

  task automatic wait_beats(input int n, output bit ok);
    for (int i = 0; i < 200 && q.size() < n; i++) tick();
    repeat (3) tick();
    ok = (q.size() == n);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) tick();
    rst = 0;
    tick();
    n_cmp++;
    if ({out_valid, out_sop, out_eop, proto_err, payload_ready} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got v/sop/eop/err/prdy=%b want 00000",
               {out_valid, out_sop, out_eop, proto_err, payload_ready});
    end
    n_cmp++;
    if ({out_data, out_byte_enable} !== 72'h0) begin
      n_err++;
      $display("FAIL reset_data: got data=%h be=%h want 0", out_data, out_byte_enable);
    end
  endtask

  task automatic test_single_ff();
    bit ok;
    logic [63:0] ed [4];
    logic [7:0]  eb [4];
    ed = '{64'h0807060504030201, 64'h100F0E0D0C0B0A09, 64'h1817161514131211, 64'h1A19};
    eb = '{8'hFF, 8'hFF, 8'hFF, 8'h03};
    send_headers();
    wait_body(ok);
    if (ok) send_beats(0, 1, 1, 8'hFF, ok);
    wait_beats(4, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL single_ff_count: got %0d beats want 4", q.size()); end
    for (int j = 0; j < 4 && j < q.size(); j++) begin
      n_cmp++;
      if (q[j].be !== eb[j] || q[j].sop !== (j == 0) || q[j].eop !== (j == 3) ||
          (q[j].d & be_mask(eb[j])) !== ed[j]) begin
        n_err++;
        $display("FAIL single_ff beat%0d: got d=%h be=%h sop=%b eop=%b want d=%h be=%h",
                 j, q[j].d, q[j].be, q[j].sop, q[j].eop, ed[j], eb[j]);
      end
    end
    q.delete();
  endtask

  task automatic test_single_0f();
    bit ok;
    logic [63:0] ed [3];
    logic [7:0]  eb [3];
    ed = '{64'h0807060504030201, 64'h100F0E0D0C0B0A09, 64'h0000161514131211};
    eb = '{8'hFF, 8'hFF, 8'h3F};
    send_headers();
    wait_body(ok);
    if (ok) send_beats(0, 1, 1, 8'h0F, ok);
    wait_beats(3, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL single_0f_count: got %0d beats want 3", q.size()); end
    for (int j = 0; j < 3 && j < q.size(); j++) begin
      n_cmp++;
      if (q[j].be !== eb[j] || q[j].sop !== (j == 0) || q[j].eop !== (j == 2) ||
          (q[j].d & be_mask(eb[j])) !== ed[j]) begin
        n_err++;
        $display("FAIL single_0f beat%0d: got d=%h be=%h sop=%b eop=%b want d=%h be=%h",
                 j, q[j].d, q[j].be, q[j].sop, q[j].eop, ed[j], eb[j]);
      end
    end
    q.delete();
  endtask

  task automatic test_three_7f();
    bit ok;
    int total, nb;
    logic [7:0] ebe;
    total = 18 + 23;            // 41 bytes: k+3 = 6 beats, last beat holds byte 0x29
    nb = (total + 7) / 8;
    send_headers();
    wait_body(ok);
    if (ok) send_beats(0, 3, 3, 8'h7F, ok);
    wait_beats(nb, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL three_7f_count: got %0d beats want %0d", q.size(), nb); end
    for (int j = 0; j < nb && j < q.size(); j++) begin
      ebe = exp_be(j, total);
      n_cmp++;
      if (q[j].be !== ebe || q[j].sop !== (j == 0) || q[j].eop !== (j == nb-1) ||
          (q[j].d & be_mask(ebe)) !== (exp_data(j) & be_mask(ebe))) begin
        n_err++;
        $display("FAIL three_7f beat%0d: got d=%h be=%h sop=%b eop=%b want d=%h be=%h",
                 j, q[j].d, q[j].be, q[j].sop, q[j].eop, exp_data(j), ebe);
      end
    end
    q.delete();
  endtask

  task automatic test_backpressure();
    bit ok;
    int total, nb;
    logic [7:0] ebe;
    total = 18 + 14;
    nb = (total + 7) / 8;
    stall_viol = 0; prdy_viol = 0; stall_seen = 0;
    tog = 1;
    send_headers();
    wait_body(ok);
    if (ok) send_beats(0, 2, 2, 8'h3F, ok);
    wait_beats(nb, ok);
    tog = 0; out_ready = 1; tick();
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL bp_count: got %0d beats want %0d", q.size(), nb); end
    for (int j = 0; j < nb && j < q.size(); j++) begin
      ebe = exp_be(j, total);
      n_cmp++;
      if (q[j].be !== ebe || q[j].sop !== (j == 0) || q[j].eop !== (j == nb-1) ||
          (q[j].d & be_mask(ebe)) !== (exp_data(j) & be_mask(ebe))) begin
        n_err++;
        $display("FAIL bp beat%0d: got d=%h be=%h sop=%b eop=%b want d=%h be=%h",
                 j, q[j].d, q[j].be, q[j].sop, q[j].eop, exp_data(j), ebe);
      end
    end
    q.delete();
    n_cmp++;
    if (stall_viol !== 0) begin n_err++; $display("FAIL bp_stable: got %0d changes want 0", stall_viol); end
    n_cmp++;
    if (prdy_viol !== 0) begin n_err++; $display("FAIL bp_prdy: got %0d ready-while-stalled want 0", prdy_viol); end
    n_cmp++;
    if (stall_seen <= 0) begin n_err++; $display("FAIL bp_stalls: got %0d stalled cycles want >0", stall_seen); end
  endtask

  task automatic test_split_headers();
    bit ok;
    int total, nb;
    logic [7:0] ebe;
    total = 18 + 8;
    nb = (total + 7) / 8;
    header_a = HA; header_b = HB; header_c = HC;
    header_a_valid = 1; tick(); header_a_valid = 0;       // cycle t
    tick(); tick();
    header_c_valid = 1; tick(); header_c_valid = 0;       // cycle t+3
    tick();
    n_cmp++;                                              // cycle t+5
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL split_early: got out_valid=%b want 0", out_valid); end
    header_b_valid = 1; tick(); header_b_valid = 0;
    n_cmp++;                                              // cycle t+6
    if (out_valid !== 1'b1 || out_sop !== 1'b1 || out_data !== 64'h0807060504030201) begin
      n_err++;
      $display("FAIL split_beat0: got v=%b sop=%b d=%h want v=1 sop=1 d=0807060504030201",
               out_valid, out_sop, out_data);
    end
    wait_body(ok);
    if (ok) send_beats(0, 1, 1, 8'hFF, ok);
    wait_beats(nb, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL split_count: got %0d beats want %0d", q.size(), nb); end
    for (int j = 0; j < nb && j < q.size(); j++) begin
      ebe = exp_be(j, total);
      n_cmp++;
      if (q[j].be !== ebe || q[j].sop !== (j == 0) || q[j].eop !== (j == nb-1) ||
          (q[j].d & be_mask(ebe)) !== (exp_data(j) & be_mask(ebe))) begin
        n_err++;
        $display("FAIL split beat%0d: got d=%h be=%h sop=%b eop=%b want d=%h be=%h",
                 j, q[j].d, q[j].be, q[j].sop, q[j].eop, exp_data(j), ebe);
      end
    end
    q.delete();
    n_cmp++;
    if (proto_err !== 1'b0) begin n_err++; $display("FAIL split_err: got proto_err=%b want 0", proto_err); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int total, nb;
    logic [7:0] ebe;
    total = 18 + 8;
    nb = (total + 7) / 8;
    send_headers();
    wait_body(ok);
    if (ok) send_beats(0, 1, 3, 8'hFF, ok);
    rst = 1; tick(); rst = 0;
    n_cmp++;
    if ({out_valid, out_sop, out_eop, proto_err, payload_ready, out_data, out_byte_enable} !== 77'h0) begin
      n_err++;
      $display("FAIL midrst_zero: got v=%b sop=%b eop=%b err=%b prdy=%b d=%h be=%h want all 0",
               out_valid, out_sop, out_eop, proto_err, payload_ready, out_data, out_byte_enable);
    end
    q.delete();
    tick();
    send_headers();
    wait_body(ok);
    if (ok) send_beats(0, 1, 1, 8'hFF, ok);
    wait_beats(nb, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL midrst_count: got %0d beats want %0d", q.size(), nb); end
    for (int j = 0; j < nb && j < q.size(); j++) begin
      ebe = exp_be(j, total);
      n_cmp++;
      if (q[j].be !== ebe || q[j].sop !== (j == 0) || q[j].eop !== (j == nb-1) ||
          (q[j].d & be_mask(ebe)) !== (exp_data(j) & be_mask(ebe))) begin
        n_err++;
        $display("FAIL midrst beat%0d: got d=%h be=%h sop=%b eop=%b want d=%h be=%h",
                 j, q[j].d, q[j].be, q[j].sop, q[j].eop, exp_data(j), ebe);
      end
    end
    q.delete();
  endtask

  task automatic test_hdr_err();
    bit ok;
    int total, nb;
    logic [7:0] ebe;
    total = 18 + 9;
    nb = (total + 7) / 8;
    n_cmp++;
    if (proto_err !== 1'b0) begin n_err++; $display("FAIL hdrerr_pre: got proto_err=%b want 0", proto_err); end
    send_headers();
    wait_body(ok);
    header_a = 48'hDEADBEEFCAFE; header_a_valid = 1; tick();
    header_a_valid = 0; header_a = HA;
    n_cmp++;
    if (proto_err !== 1'b1) begin n_err++; $display("FAIL hdrerr_set: got proto_err=%b want 1", proto_err); end
    if (ok) send_beats(0, 2, 2, 8'h01, ok);
    wait_beats(nb, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL hdrerr_count: got %0d beats want %0d", q.size(), nb); end
    for (int j = 0; j < nb && j < q.size(); j++) begin
      ebe = exp_be(j, total);
      n_cmp++;
      if (q[j].be !== ebe || q[j].sop !== (j == 0) || q[j].eop !== (j == nb-1) ||
          (q[j].d & be_mask(ebe)) !== (exp_data(j) & be_mask(ebe))) begin
        n_err++;
        $display("FAIL hdrerr beat%0d: got d=%h be=%h sop=%b eop=%b want d=%h be=%h",
                 j, q[j].d, q[j].be, q[j].sop, q[j].eop, exp_data(j), ebe);
      end
    end
    q.delete();
    n_cmp++;
    if (proto_err !== 1'b1) begin n_err++; $display("FAIL hdrerr_sticky: got proto_err=%b want 1", proto_err); end
  endtask

  initial begin
    test_reset();
    test_single_ff();
    test_single_0f();
    test_three_7f();
    test_backpressure();
    test_split_headers();
    test_mid_reset();
    test_hdr_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
